// File: rtl/ready_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ready_wait_ctrl
// Purpose  : Per-channel ready/wait handshake tracker with saturating wait
//            counters, optional timeout abort and level/edge arming.
// Revision : 1.0 - initial release
// ============================================================================
module ready_wait_ctrl #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ready,
  input  logic [NCH-1:0]       readyp,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       tout,
  output logic [NCH*CNT_W-1:0] wait_cnt,
  output logic                 any_busy
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_WAIT  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             TO_EN    = (TIMEOUT != 0);
  localparam int               TO_M1    = (TIMEOUT != 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_M1);

  logic [NCH-1:0] ready_prev_q;
  logic [NCH-1:0] ready_prev_d;
  logic [NCH-1:0] arm;
  logic [NCH-1:0] busy_nxt;
  logic           any_busy_q;
  logic           any_busy_d;

  // History is tracked every cycle so an edge is only seen on a true 0->1.
  always_comb begin
    ready_prev_d = ready;
    any_busy_d   = |busy_nxt;
  end

  assign arm = (EDGE_MODE != 0) ? (ready & ~ready_prev_q) : ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_prev_q <= '0;
      any_busy_q   <= 1'b0;
    end else begin
      ready_prev_q <= ready_prev_d;
      any_busy_q   <= any_busy_d;
    end
  end

  assign any_busy = any_busy_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      done_d  = 1'b0;
      tout_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm[i]) begin
            if (readyp[i]) begin
              done_d = 1'b1;
              wcnt_d = '0;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = '0;
            end
          end
        end
        ST_WAIT: begin
          // Completion wins over a coincident timeout.
          if (readyp[i]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            wcnt_d  = cnt_inc;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = ST_IDLE;
            tout_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        wcnt_q  <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        tout_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        wcnt_q  <= wcnt_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
        tout_q  <= tout_d;
      end
    end

    assign busy_nxt[i]                = busy_d;
    assign busy[i]                    = busy_q;
    assign done[i]                    = done_q;
    assign tout[i]                    = tout_q;
    assign wait_cnt[i*CNT_W +: CNT_W] = wcnt_q;
  end

endmodule
`default_nettype wire
